gcd_driver: RTL and testbench
=============================

GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the request FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for gcd_done (1..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  host offers an operand pair.
REQ-006 req_ready  output  1  request FIFO not full.
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 rsp_valid  output  1  response held valid.
REQ-009 rsp_ready  input  1  host accepts the response.
REQ-010 rsp_result  output  8  GCD value.
REQ-011 rsp_err  output  1  both operands zero, or timeout.
REQ-012 gcd_go  output  1  start pulse to the GCD engine.
REQ-013 gcd_a, gcd_b  output  8 each  operands to the engine's data lines.
REQ-014 gcd_done  input  1  engine completion level.
REQ-015 gcd_result  input  8  engine result.

Function
REQ-016 A request SHALL be written to the FIFO when req_valid and req_ready are both high on a clk edge; order SHALL be preserved.
REQ-017 The FSM SHALL use states IDLE, ISSUE, WAIT, RESP, RELEASE.
REQ-018 IDLE SHALL pop the FIFO head when the FIFO is non-empty and rsp_valid is low; it SHALL then go to RESP if either operand is zero, else to ISSUE.
REQ-019 Zero bypass SHALL give these results: a=0,b!=0 -> rsp_result=b; b=0,a!=0 -> rsp_result=a; both zero -> rsp_result=0 with rsp_err=1. gcd_go SHALL NOT be asserted for a zero bypass.
REQ-020 ISSUE SHALL drive gcd_go high for exactly one cycle, then go to WAIT.
REQ-021 gcd_a and gcd_b SHALL be loaded from the popped entry and held stable from ISSUE until RELEASE exits.
REQ-022 WAIT SHALL capture gcd_result on the first cycle gcd_done=1 and go to RESP with rsp_err=0.
REQ-023 RESP SHALL hold rsp_valid high with stable rsp_result and rsp_err until rsp_ready=1, then clear rsp_valid.
- Next state: RELEASE if the job used the engine, else IDLE.
REQ-024 RELEASE SHALL wait until gcd_done=0, then go to IDLE, so that no new gcd_go is issued while done is still high.
REQ-025 Latency for a non-zero pair SHALL be: pop -> gcd_go one cycle later; gcd_done sampled high -> rsp_valid high the next cycle.
REQ-026 When the FIFO is full, req_ready SHALL be 0; a simultaneous push and pop on a full FIFO SHALL NOT be allowed.
- A simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-028 While rst=0, the FSM SHALL be in IDLE and the FIFO empty.
- Outputs: req_ready=1; rsp_valid=0; rsp_result=0; rsp_err=0; gcd_go=0; gcd_a=0; gcd_b=0; timeout counter=0.
REQ-029 Reset asserted mid-job SHALL abandon the job and drop all queued requests.
- Outputs SHALL reach their reset values asynchronously, without waiting for a clock edge.

Configuration
REQ-030 Macro GCD_DRV_TIMEOUT_EN SHALL compile in a 16-bit watchdog.
- With the macro defined:
  - The counter SHALL clear on entering WAIT or RELEASE and increment each cycle in those states.
  - In WAIT, reaching TIMEOUT SHALL go to RESP with rsp_result=0, rsp_err=1.
  - In RELEASE, reaching TIMEOUT SHALL force IDLE.
- Without the macro: no counter SHALL exist; WAIT and RELEASE SHALL wait indefinitely; rsp_err SHALL be set only by the both-zero case.

Verification
REQ-031 Push (48,18) with rsp_ready=1 and an engine model done after 10 cycles -> exactly one gcd_go pulse, gcd_a=48, gcd_b=18; then rsp_result=6, rsp_err=0.
REQ-032 Push (0,35), then (0,0) -> no gcd_go; responses in order: rsp_result=35 rsp_err=0, then rsp_result=0 rsp_err=1.
REQ-033 Push 6 pairs with rsp_ready=0 and FIFO_DEPTH=4 -> req_ready=0 once the FIFO holds 4 entries.
- Release rsp_ready -> all accepted pairs answered in order; pairs pushed while req_ready=0 are not accepted.
REQ-034 With GCD_DRV_TIMEOUT_EN defined, TIMEOUT=20, gcd_done tied 0, push (9,6) -> rsp_valid with rsp_result=0, rsp_err=1, 21 cycles after gcd_go.
REQ-035 Engine holds gcd_done=1 for 5 cycles after the result; push (12,8),(9,3) -> results 4 then 3.
- The second gcd_go SHALL occur only after gcd_done falls.
REQ-036 Assert rst=0 during WAIT with 2 entries queued -> all outputs reach reset values without a clock edge.
- After release of rst, the next push (7,7) -> rsp_result=7.

Source files
------------

// File: rtl/gcd_driver.sv
// Request FIFO + sequencer that feeds operand pairs to an external GCD engine and returns results.
// Optional watchdog on engine handshake compiled in with `define GCD_DRV_TIMEOUT_EN.
module gcd_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic       gcd_go,
  output logic [7:0] gcd_a,
  output logic [7:0] gcd_b,
  input  logic       gcd_done,
  input  logic [7:0] gcd_result
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  generate
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
      $error("gcd_driver: illegal FIFO_DEPTH or TIMEOUT");
    end
  endgenerate

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, used_q, used_d;
  logic [7:0]    rsp_result_q, rsp_result_d, gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic          push, pop;
  logic [7:0]    ha, hb;
`ifdef GCD_DRV_TIMEOUT_EN
  logic [15:0]   to_cnt_q, to_cnt_d;
  logic          to_hit;
`endif

  assign req_ready  = (cnt_q != CW'(FIFO_DEPTH));
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign gcd_go     = (state_q == S_ISSUE);
  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;

  always_comb begin
    push         = req_valid && req_ready;
    pop          = (state_q == S_IDLE) && (cnt_q != '0) && !rsp_valid_q;
    ha           = mem_q[rd_ptr_q][15:8];
    hb           = mem_q[rd_ptr_q][7:0];
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    cnt_d        = cnt_q + CW'(push) - CW'(pop);
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    gcd_a_d      = gcd_a_q;
    gcd_b_d      = gcd_b_q;
    used_d       = used_q;
`ifdef GCD_DRV_TIMEOUT_EN
    to_hit       = (to_cnt_q == 16'(TIMEOUT - 1));
`endif
    case (state_q)
      S_IDLE: if (pop) begin
        if (ha == 8'd0 || hb == 8'd0) begin
          // zero bypass: answer directly, engine never sees the pair
          rsp_valid_d  = 1'b1;
          rsp_result_d = (ha == 8'd0) ? hb : ha;
          rsp_err_d    = (ha == 8'd0) && (hb == 8'd0);
          used_d       = 1'b0;
          state_d      = S_RESP;
        end else begin
          gcd_a_d = ha;
          gcd_b_d = hb;
          used_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (gcd_done) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = gcd_result;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end
`ifdef GCD_DRV_TIMEOUT_EN
        else if (to_hit) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = 8'd0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end
`endif
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = used_q ? S_REL : S_IDLE;
      end
      // hold off the next go until the engine drops its done level
      S_REL: begin
        if (!gcd_done) state_d = S_IDLE;
`ifdef GCD_DRV_TIMEOUT_EN
        else if (to_hit) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef GCD_DRV_TIMEOUT_EN
    to_cnt_d = ((state_d == S_WAIT || state_d == S_REL) && state_d == state_q) ?
               to_cnt_q + 16'd1 : 16'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_a, req_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_err_q    <= 1'b0;
      gcd_a_q      <= 8'd0;
      gcd_b_q      <= 8'd0;
      used_q       <= 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
      to_cnt_q     <= 16'd0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      gcd_a_q      <= gcd_a_d;
      gcd_b_q      <= gcd_b_d;
      used_q       <= used_d;
`ifdef GCD_DRV_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_gcd_driver.sv
// Directed + random bench for gcd_driver with a behavioural GCD engine and response scoreboard.
module tb_gcd_driver;
  logic       clk, rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic       gcd_go, gcd_done;
  logic [7:0] req_a, req_b, rsp_result, gcd_a, gcd_b, gcd_result;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, go_cnt = 0, gwd = 0;
  logic [7:0] go_a, go_b;
  logic [8:0] exp_q[$], obs_q[$];

  int eng_lat = 3, eng_hold = 1;
  bit eng_tie0 = 0;
  int eng_cnt, eng_hold_cnt;
  bit eng_busy;
  logic [7:0] eng_res;

  gcd_driver #(.FIFO_DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .gcd_go(gcd_go), .gcd_a(gcd_a),
    .gcd_b(gcd_b), .gcd_done(gcd_done), .gcd_result(gcd_result));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // expected {err, result} for one operand pair
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 && b == 0) return {1'b1, 8'd0};
    if (a == 0) return {1'b0, b};
    if (b == 0) return {1'b0, a};
    return {1'b0, ref_gcd(a, b)};
  endfunction

  // engine: done rises eng_lat cycles after go, stays high eng_hold cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcd_done <= 0; gcd_result <= 0; eng_busy <= 0; eng_cnt <= 0; eng_hold_cnt <= 0;
    end else if (gcd_go && !eng_tie0) begin
      eng_busy <= 1; eng_cnt <= eng_lat; eng_res <= ref_gcd(gcd_a, gcd_b);
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_busy <= 0; gcd_done <= 1; gcd_result <= eng_res; eng_hold_cnt <= eng_hold;
      end else eng_cnt <= eng_cnt - 1;
    end else if (gcd_done) begin
      if (eng_hold_cnt <= 1) gcd_done <= 0;
      else eng_hold_cnt <= eng_hold_cnt - 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_result});
      if (gcd_go) begin
        go_cnt <= go_cnt + 1; go_a <= gcd_a; go_b <= gcd_b;
        if (gcd_done) gwd <= gwd + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_try(input logic [7:0] a, input logic [7:0] b, output bit acc);
    req_a = a; req_b = b; req_valid = 1;
    acc = req_ready;
    tick();
    req_valid = 0;
    if (acc) exp_q.push_back(model(a, b));
  endtask

  task automatic push_wait(input logic [7:0] a, input logic [7:0] b, input bit rnd);
    bit acc;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      push_try(a, b, acc);
    end
    check("push_acc", 32'(acc), 1);
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1;
    for (int n = 0; n < 3000 && obs_q.size() < exp_q.size(); n++) tick();
    repeat (8) tick();
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_rsp%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    int g0, acc_n, t0, t1;
    bit acc;
    logic [7:0] a, b;
    rst = 0; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_gcd_go", 32'(gcd_go), 0);
    check("rst_gcd_a", 32'(gcd_a), 0);
    check("rst_gcd_b", 32'(gcd_b), 0);
    rst = 1;
    tick();

    // single engine job
    eng_lat = 10; eng_hold = 1; g0 = go_cnt;
    push_wait(48, 18, 0);
    drain("t48_18");
    check("t48_go_cnt", 32'(go_cnt - g0), 1);
    check("t48_go_a", 32'(go_a), 48);
    check("t48_go_b", 32'(go_b), 18);

    // zero bypass
    g0 = go_cnt;
    push_wait(0, 35, 0);
    push_wait(0, 0, 0);
    drain("zero");
    check("zero_no_go", 32'(go_cnt - g0), 0);

    // FIFO fill with response stalled
    eng_lat = 2; rsp_ready = 0; acc_n = 0;
    push_try(10, 4, acc);   acc_n += int'(acc);
    push_try(0, 9, acc);    acc_n += int'(acc);
    push_try(21, 14, acc);  acc_n += int'(acc);
    push_try(100, 0, acc);  acc_n += int'(acc);
    push_try(17, 5, acc);   acc_n += int'(acc);
    push_try(33, 11, acc);  acc_n += int'(acc);
    repeat (4) tick();
    check("full_req_ready", 32'(req_ready), 0);
    check("full_accepted", 32'(acc_n), 5);
    drain("full");

    // engine holds done after the result
    eng_lat = 3; eng_hold = 5; g0 = go_cnt; t0 = gwd;
    push_wait(12, 8, 0);
    push_wait(9, 3, 0);
    drain("hold");
    check("hold_go_cnt", 32'(go_cnt - g0), 2);
    check("hold_go_while_done", 32'(gwd - t0), 0);

    // random traffic
    for (int k = 0; k < 24; k++) begin
      a = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      eng_lat = $urandom_range(1, 6); eng_hold = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) begin rsp_ready = 1'($urandom_range(0, 1)); tick(); end
      push_wait(a, b, 1);
    end
    drain("rand");
    eng_hold = 1;

`ifdef GCD_DRV_TIMEOUT_EN
    // watchdog: engine never answers
    eng_tie0 = 1; t0 = -1; t1 = -1;
    push_wait(9, 6, 0);
    for (int n = 0; n < 100 && t1 < 0; n++) begin
      tick();
      if (gcd_go && t0 < 0) t0 = cyc;
      if (rsp_valid) t1 = cyc;
    end
    check("to_latency", 32'(t1 - t0), 21);
    check("to_result", 32'(rsp_result), 0);
    check("to_err", 32'(rsp_err), 1);
    drain("to");
    eng_tie0 = 0;
`endif

    // reset mid-job with entries queued
    eng_tie0 = 1; rsp_ready = 1;
    push_wait(100, 75, 0);
    push_wait(20, 30, 0);
    push_wait(5, 10, 0);
`ifdef GCD_DRV_TIMEOUT_EN
    repeat (8) tick();
`else
    repeat (40) tick();
    check("nowd_still_waiting", 32'(rsp_valid), 0);
`endif
    check("pre_rst_gcd_a", 32'(gcd_a), 100);
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("arst_req_ready", 32'(req_ready), 1);
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_result", 32'(rsp_result), 0);
    check("arst_rsp_err", 32'(rsp_err), 0);
    check("arst_gcd_go", 32'(gcd_go), 0);
    check("arst_gcd_a", 32'(gcd_a), 0);
    check("arst_gcd_b", 32'(gcd_b), 0);
    exp_q.delete(); obs_q.delete();
    eng_tie0 = 0; eng_lat = 3;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    tick();
    push_wait(7, 7, 0);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
